// File: rtl/sha_pkg.sv
// ---------------------------------------------------------------------------
// sha_pkg
//   Shared definitions for the nonce selection block:
//     - scan FSM state encoding
//     - default number of hash words scanned per run
//     - result-record layout written back to memory
//     - best-candidate record and the packing helper for the nonce word
// ---------------------------------------------------------------------------
package sha_pkg;

    // Number of consecutive hash words examined per scan unless overridden.
    localparam int unsigned NUM_NONCES_DEFAULT = 16;

    // Result record, relative to result_addr:
    //   word 0 : best (minimum) hash
    //   word 1 : {found, best_nonce[30:0]}
    localparam logic [15:0] RESULT_HASH_WORD  = 16'd0;
    localparam logic [15:0] RESULT_NONCE_WORD = 16'd1;

    // Starting value of the running minimum; any real hash ties or beats it.
    localparam logic [31:0] HASH_INIT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        READ        = 2'd1,
        WRITE_HASH  = 2'd2,
        WRITE_NONCE = 2'd3
    } state_e;

    typedef struct packed {
        logic [31:0] hash;
        logic [31:0] nonce;
    } best_t;

    // Second result word: found flag in bit 31, low 31 bits of the nonce.
    function automatic logic [31:0] pack_nonce_word(input logic        found,
                                                    input logic [31:0] nonce);
        return {found, nonce[30:0]};
    endfunction

endpackage

// File: rtl/hash_min_cmp.sv
// ---------------------------------------------------------------------------
// hash_min_cmp
//   Combinational compare of one incoming hash/nonce pair against the
//   running best and the difficulty target.
//
//   Ports
//     hash_i          incoming hash word (unsigned)
//     nonce_i         nonce the incoming hash belongs to
//     best_i          current best {hash, nonce}
//     target_i        difficulty threshold (unsigned)
//     best_o          updated best {hash, nonce}
//     below_target_o  incoming hash is strictly below target
// ---------------------------------------------------------------------------
module hash_min_cmp
    import sha_pkg::*;
(
    input  logic [31:0] hash_i,
    input  logic [31:0] nonce_i,
    input  best_t       best_i,
    input  logic [31:0] target_i,
    output best_t       best_o,
    output logic        below_target_o
);

    logic lower_hash;
    logic tie_lower_nonce;
    logic take_new;

    assign lower_hash      = (hash_i < best_i.hash);
    // Nonces normally arrive in ascending order so ties resolve to the
    // earlier one anyway; the explicit check keeps that true regardless.
    assign tie_lower_nonce = (hash_i == best_i.hash) && (nonce_i < best_i.nonce);
    assign take_new        = lower_hash || tie_lower_nonce;

    always_comb begin
        best_o = best_i;
        if (take_new) begin
            best_o.hash  = hash_i;
            best_o.nonce = nonce_i;
        end
    end

    assign below_target_o = (hash_i < target_i);

endmodule

// File: rtl/nonce_select.sv
// ---------------------------------------------------------------------------
// nonce_select
//   Scans NUM_NONCES consecutive hash words from a synchronous memory,
//   tracks the minimum hash and whether any hash fell below the target,
//   then writes a two-word result record back to memory.
//
//   Pipeline: a read is issued in READ, its data returns on the next cycle
//   and is registered, and the compare happens the cycle after that. The
//   scan therefore takes NUM_NONCES + 4 cycles from start to done.
//
//   Ports
//     clk             clock, all state changes on rising edge
//     reset           asynchronous active-high reset
//     start           begin a scan (sampled only in IDLE)
//     hash_addr       word address of the hash for nonce 0
//     result_addr     word address of the result record
//     target          difficulty threshold, unsigned
//     done            high while idle
//     found           a hash strictly below target was seen in the last scan
//     best_nonce      index of the minimum hash
//     best_hash       minimum hash value
//     mem_clk         memory clock (same as clk)
//     mem_we          memory write enable
//     mem_addr        memory word address
//     mem_write_data  memory write data
//     mem_read_data   memory read data (word addressed on the previous cycle)
// ---------------------------------------------------------------------------
module nonce_select
    import sha_pkg::*;
#(
    parameter int unsigned NUM_NONCES = NUM_NONCES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] hash_addr,
    input  logic [15:0] result_addr,
    input  logic [31:0] target,
    output logic        done,
    output logic        found,
    output logic [31:0] best_nonce,
    output logic [31:0] best_hash,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    localparam logic [31:0] NUM_W = 32'(NUM_NONCES);

    state_e      state_q,       state_d;
    logic [15:0] hash_addr_q,   hash_addr_d;
    logic [15:0] result_addr_q, result_addr_d;
    logic [31:0] target_q,      target_d;
    logic [31:0] offset_q,      offset_d;

    // Read issued last cycle; its data is on mem_read_data this cycle.
    logic        rd_pend_q,     rd_pend_d;
    logic [31:0] rd_nonce_q,    rd_nonce_d;

    // Registered returned word awaiting compare.
    logic        cap_valid_q,   cap_valid_d;
    logic [31:0] cap_hash_q,    cap_hash_d;
    logic [31:0] cap_nonce_q,   cap_nonce_d;

    logic        found_q,       found_d;
    best_t       best_q,        best_d;

    best_t       cmp_best;
    logic        cmp_below;
    logic        issue;

    hash_min_cmp u_cmp (
        .hash_i         (cap_hash_q),
        .nonce_i        (cap_nonce_q),
        .best_i         (best_q),
        .target_i       (target_q),
        .best_o         (cmp_best),
        .below_target_o (cmp_below)
    );

    assign issue = (state_q == READ) && (offset_q != NUM_W);

    always_comb begin
        state_d       = state_q;
        hash_addr_d   = hash_addr_q;
        result_addr_d = result_addr_q;
        target_d      = target_q;
        offset_d      = offset_q;
        rd_pend_d     = issue;
        rd_nonce_d    = issue ? offset_q : rd_nonce_q;
        cap_valid_d   = rd_pend_q;
        cap_hash_d    = rd_pend_q ? mem_read_data : cap_hash_q;
        cap_nonce_d   = rd_pend_q ? rd_nonce_q    : cap_nonce_q;
        found_d       = found_q;
        best_d        = best_q;

        if (cap_valid_q) begin
            best_d = cmp_best;
            if (cmp_below) begin
                found_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    hash_addr_d   = hash_addr;
                    result_addr_d = result_addr;
                    target_d      = target;
                    offset_d      = '0;
                    rd_pend_d     = 1'b0;
                    cap_valid_d   = 1'b0;
                    found_d       = 1'b0;
                    best_d        = '{hash: HASH_INIT, nonce: '0};
                    state_d       = READ;
                end
            end
            READ: begin
                if (issue) begin
                    offset_d = offset_q + 32'd1;
                end else if (!rd_pend_q) begin
                    // Last word is registered now and compares this cycle,
                    // so best is final by the time WRITE_HASH drives it.
                    state_d = WRITE_HASH;
                end
            end
            WRITE_HASH:  state_d = WRITE_NONCE;
            WRITE_NONCE: state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            hash_addr_q   <= '0;
            result_addr_q <= '0;
            target_q      <= '0;
            offset_q      <= '0;
            rd_pend_q     <= 1'b0;
            rd_nonce_q    <= '0;
            cap_valid_q   <= 1'b0;
            cap_hash_q    <= '0;
            cap_nonce_q   <= '0;
            found_q       <= 1'b0;
            best_q        <= '{hash: HASH_INIT, nonce: '0};
        end else begin
            state_q       <= state_d;
            hash_addr_q   <= hash_addr_d;
            result_addr_q <= result_addr_d;
            target_q      <= target_d;
            offset_q      <= offset_d;
            rd_pend_q     <= rd_pend_d;
            rd_nonce_q    <= rd_nonce_d;
            cap_valid_q   <= cap_valid_d;
            cap_hash_q    <= cap_hash_d;
            cap_nonce_q   <= cap_nonce_d;
            found_q       <= found_d;
            best_q        <= best_d;
        end
    end

    // Memory port is decoded from state alone so an asynchronous reset
    // drops mem_we immediately, cutting off any result write in flight.
    always_comb begin
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_write_data = '0;
        case (state_q)
            READ: begin
                mem_addr = hash_addr_q + offset_q[15:0];
            end
            WRITE_HASH: begin
                mem_we         = 1'b1;
                mem_addr       = result_addr_q + RESULT_HASH_WORD;
                mem_write_data = best_q.hash;
            end
            WRITE_NONCE: begin
                mem_we         = 1'b1;
                mem_addr       = result_addr_q + RESULT_NONCE_WORD;
                mem_write_data = pack_nonce_word(found_q, best_q.nonce);
            end
            default: ;
        endcase
    end

    assign mem_clk    = clk;
    assign done       = (state_q == IDLE);
    assign found      = found_q;
    assign best_nonce = best_q.nonce;
    assign best_hash  = best_q.hash;

endmodule

// File: tb/tb_nonce_select.sv
// ---------------------------------------------------------------------------
// tb_nonce_select
//   Directed bench for nonce_select with a synchronous 64K x 32 memory model.
// ---------------------------------------------------------------------------
module tb_nonce_select;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] hash_addr;
    logic [15:0] result_addr;
    logic [31:0] target;
    logic        done;
    logic        found;
    logic [31:0] best_nonce;
    logic [31:0] best_hash;
    logic        mem_clk;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    logic [31:0] mem [0:65535];
    logic        tb_we;
    logic [15:0] tb_addr;
    logic [31:0] tb_data;
    int unsigned we_count = 0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    nonce_select #(.NUM_NONCES(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .hash_addr      (hash_addr),
        .result_addr    (result_addr),
        .target         (target),
        .done           (done),
        .found          (found),
        .best_nonce     (best_nonce),
        .best_hash      (best_hash),
        .mem_clk        (mem_clk),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    // Synchronous memory; bench preload uses a side port when the DUT is not writing.
    always @(posedge mem_clk) begin
        if (mem_we === 1'b1) begin
            mem[mem_addr] <= mem_write_data;
            we_count      <= we_count + 1;
        end else if (tb_we) begin
            mem[tb_addr] <= tb_data;
        end
        mem_read_data <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [31:0] d);
        @(negedge clk);
        tb_we   = 1'b1;
        tb_addr = a;
        tb_data = d;
        @(posedge clk);
        #1 tb_we = 1'b0;
    endtask

    // Start one scan, optionally check the 16 issued read addresses, and
    // return how many rising edges after the start edge done came back.
    task automatic run_scan(input logic [15:0] ha, input logic [15:0] ra,
                            input logic [31:0] tg, input bit chk_addr,
                            input string tag, output int lat);
        logic [15:0] ea;
        @(negedge clk);
        hash_addr   = ha;
        result_addr = ra;
        target      = tg;
        start       = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            if (chk_addr && i <= 16) begin
                ea = ha + 16'(i - 1);
                chk({tag, "_addr"}, {16'h0, mem_addr}, {16'h0, ea});
            end
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic chk_result(input string tag, input logic [15:0] ra,
                              input logic [31:0] e_found, input logic [31:0] e_hash,
                              input logic [31:0] e_nonce, input logic [31:0] e_w1);
        logic [15:0] ra1;
        ra1 = ra + 16'd1;
        chk({tag, "_found"},  {31'h0, found}, e_found);
        chk({tag, "_hash"},   best_hash,      e_hash);
        chk({tag, "_nonce"},  best_nonce,     e_nonce);
        chk({tag, "_mem_w0"}, mem[ra],        e_hash);
        chk({tag, "_mem_w1"}, mem[ra1],       e_w1);
    endtask

    initial begin
        int          lat;
        int unsigned wc0;
        int          n;

        reset       = 1'b1;
        start       = 1'b0;
        hash_addr   = '0;
        result_addr = '0;
        target      = '0;
        tb_we       = 1'b0;
        tb_addr     = '0;
        tb_data     = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_done",   {31'h0, done},   32'h1);
        chk("rst_found",  {31'h0, found},  32'h0);
        chk("rst_hash",   best_hash,       32'hFFFF_FFFF);
        chk("rst_nonce",  best_nonce,      32'h0);
        chk("rst_we",     {31'h0, mem_we}, 32'h0);
        chk("rst_addr",   {16'h0, mem_addr}, 32'h0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1 chk("rel_done", {31'h0, done}, 32'h1);

        // Preload hash regions
        for (int i = 0; i < 16; i++) poke(16'h0100 + 16'(i), 32'(100 + i));
        for (int i = 0; i < 16; i++) poke(16'h0300 + 16'(i), (i == 9) ? 32'h10 : 32'h8000_0000);
        for (int i = 0; i < 16; i++) poke(16'h0500 + 16'(i), (i == 3 || i == 12) ? 32'h5 : 32'h100);
        for (int i = 0; i < 16; i++) poke(16'hFFF8 + 16'(i), (i == 10) ? 32'h7 : 32'(200 + i));

        // No hash below target
        wc0 = we_count;
        run_scan(16'h0100, 16'h0200, 32'd50, 1'b0, "none", lat);
        chk("none_lat", lat, 20);
        chk("none_we", we_count - wc0, 2);
        chk_result("none", 16'h0200, 0, 32'd100, 0, 32'h0);

        // Single low hash at nonce 9
        wc0 = we_count;
        run_scan(16'h0300, 16'h0400, 32'h1000, 1'b0, "one", lat);
        chk("one_lat", lat, 20);
        chk("one_we", we_count - wc0, 2);
        chk_result("one", 16'h0400, 1, 32'h10, 9, 32'h8000_0009);

        // Tie at nonces 3 and 12 keeps the lower nonce
        wc0 = we_count;
        run_scan(16'h0500, 16'h0600, 32'h6, 1'b0, "tie", lat);
        chk("tie_lat", lat, 20);
        chk_result("tie", 16'h0600, 1, 32'h5, 3, 32'h8000_0003);

        // Address wrap on reads and on the result record
        wc0 = we_count;
        run_scan(16'hFFF8, 16'hFFFF, 32'h0, 1'b1, "wrap", lat);
        chk("wrap_lat", lat, 20);
        chk("wrap_we", we_count - wc0, 2);
        chk_result("wrap", 16'hFFFF, 0, 32'h7, 10, 32'h0000_000A);

        // Reset during READ cycle 8
        @(negedge clk);
        hash_addr   = 16'h0300;
        result_addr = 16'h0240;
        target      = 32'hFFFF_FFFF;
        start       = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("mid_found", {31'h0, found}, 32'h1);
        chk("mid_hash",  best_hash, 32'h8000_0000);
        chk("mid_done",  {31'h0, done}, 32'h0);
        wc0 = we_count;
        #2 reset = 1'b1;
        #1;
        chk("mrst_done",  {31'h0, done},     32'h1);
        chk("mrst_found", {31'h0, found},    32'h0);
        chk("mrst_hash",  best_hash,         32'hFFFF_FFFF);
        chk("mrst_nonce", best_nonce,        32'h0);
        chk("mrst_we",    {31'h0, mem_we},   32'h0);
        chk("mrst_addr",  {16'h0, mem_addr}, 32'h0);
        @(posedge clk);
        @(negedge clk) reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("mrst_idle", {31'h0, done}, 32'h1);
        chk("mrst_nowe", we_count - wc0, 0);

        wc0 = we_count;
        run_scan(16'h0100, 16'h0260, 32'd50, 1'b1, "again", lat);
        chk("again_lat", lat, 20);
        chk("again_we", we_count - wc0, 2);
        chk_result("again", 16'h0260, 0, 32'd100, 0, 32'h0);

        // Start held high across two scans
        wc0 = we_count;
        @(negedge clk);
        hash_addr   = 16'h0500;
        result_addr = 16'h0700;
        target      = 32'h6;
        start       = 1'b1;
        @(posedge clk);
        n = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                n = i;
                break;
            end
        end
        chk("hold_lat1", n, 20);
        chk("hold_we1", we_count - wc0, 2);
        chk("hold_w1", mem[16'h0701], 32'h8000_0003);
        @(posedge clk);
        #1;
        chk("hold_rescan_done", {31'h0, done}, 32'h0);
        chk("hold_rescan_addr", {16'h0, mem_addr}, 32'h0000_0500);
        n = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                n = i;
                break;
            end
        end
        chk("hold_lat2", n, 20);
        chk("hold_we2", we_count - wc0, 4);
        @(negedge clk) start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("hold_end_done", {31'h0, done}, 32'h1);
        chk("hold_end_we", we_count - wc0, 4);
        chk("hold_nonce", best_nonce, 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
